// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot loader: packs a byte stream into 32-bit words, zero-fills the rest,
// then hands the fetch port to the CPU. Optional checksum byte check under `CHECKSUM_EN.
module imem_boot_ctrl #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [31:0]       pc,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CLEAR = 3'd2,
        S_RUN   = 3'd3,
        S_CHK   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t              state_r;
    logic [1:0]          byte_cnt_r;
    logic [ADDR_W-1:0]   word_cnt_r;
    logic [23:0]         shift_r;
    logic [ADDR_W:0]     len_r;
    logic [ADDR_W-1:0]   clr_addr_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic                in_ready_r;
    logic                mem_we_r;
    logic [31:0]         mem_wdata_r;
    logic                cpu_run_r;
    logic                busy_r;
    logic                err_r;
`ifdef CHECKSUM_EN
    logic [7:0]          xor_r;
`endif

    logic [ADDR_W:0]     len_s;
    logic                launch_s;
    logic                accept_s;
    logic                last_word_s;
    logic                full_s;
    logic                pc_unused;

    assign len_s       = (load_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : load_len;
    assign launch_s    = start && ((state_r == S_IDLE) || (state_r == S_RUN) || (state_r == S_ERR));
    assign accept_s    = in_valid && in_ready_r;
    assign last_word_s = ({1'b0, word_cnt_r} == (len_r - (ADDR_W+1)'(1)));
    assign full_s      = (len_r == (ADDR_W+1)'(DEPTH));
    assign pc_unused   = ^{pc[31:ADDR_W+2], pc[1:0]};

    // Fetch address is combinational from the PC once the CPU is released
    assign mem_addr  = cpu_run_r ? pc[ADDR_W+1:2] : wr_addr_r;
    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_run   = cpu_run_r;
    assign busy      = busy_r;
    assign err       = err_r;

    // Controller FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            byte_cnt_r  <= 2'd0;
            word_cnt_r  <= '0;
            shift_r     <= 24'd0;
            len_r       <= '0;
            clr_addr_r  <= '0;
            wr_addr_r   <= '0;
            in_ready_r  <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 32'd0;
            cpu_run_r   <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
`ifdef CHECKSUM_EN
            xor_r       <= 8'd0;
`endif
        end else begin
            mem_we_r <= 1'b0;
            if (launch_s) begin
                len_r      <= len_s;
                byte_cnt_r <= 2'd0;
                word_cnt_r <= '0;
                shift_r    <= 24'd0;
                clr_addr_r <= '0;
                cpu_run_r  <= 1'b0;
                busy_r     <= 1'b1;
                err_r      <= 1'b0;
`ifdef CHECKSUM_EN
                xor_r      <= 8'd0;
`endif
                if (len_s == (ADDR_W+1)'(0)) begin
                    state_r    <= S_CLEAR;
                    in_ready_r <= 1'b0;
                end else begin
                    state_r    <= S_LOAD;
                    in_ready_r <= 1'b1;
                end
            end else begin
                case (state_r)
                    S_IDLE: begin
                        in_ready_r <= 1'b0;
                    end
                    S_LOAD: begin
                        if (accept_s) begin
                            shift_r    <= {shift_r[15:0], in_data};
                            byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef CHECKSUM_EN
                            xor_r      <= xor_r ^ in_data;
`endif
                            if (byte_cnt_r == 2'd3) begin
                                mem_we_r    <= 1'b1;
                                wr_addr_r   <= word_cnt_r;
                                mem_wdata_r <= {shift_r, in_data};
                                word_cnt_r  <= word_cnt_r + ADDR_W'(1);
                                if (last_word_s) begin
`ifdef CHECKSUM_EN
                                    state_r <= S_CHK;
`else
                                    in_ready_r <= 1'b0;
                                    clr_addr_r <= len_r[ADDR_W-1:0];
                                    state_r    <= full_s ? S_RUN : S_CLEAR;
`endif
                                end
                            end
                        end
                    end
`ifdef CHECKSUM_EN
                    S_CHK: begin
                        if (accept_s) begin
                            in_ready_r <= 1'b0;
                            if (in_data == xor_r) begin
                                clr_addr_r <= len_r[ADDR_W-1:0];
                                state_r    <= full_s ? S_RUN : S_CLEAR;
                            end else begin
                                err_r   <= 1'b1;
                                busy_r  <= 1'b0;
                                state_r <= S_ERR;
                            end
                        end
                    end
                    S_ERR: begin
                        in_ready_r <= 1'b0;
                    end
`endif
                    S_CLEAR: begin
                        mem_we_r    <= 1'b1;
                        wr_addr_r   <= clr_addr_r;
                        mem_wdata_r <= 32'd0;
                        clr_addr_r  <= clr_addr_r + ADDR_W'(1);
                        if (clr_addr_r == ADDR_W'(DEPTH-1)) begin
                            state_r <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        cpu_run_r <= 1'b1;
                        busy_r    <= 1'b0;
                    end
                    default: begin
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized self-checking bench for imem_boot_ctrl; expected write sequence is derived from
// the program bytes (packed words, then zero fill) independently of the controller's internals.
module tb_imem_boot_ctrl;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   load_len = '0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic [31:0]       pc = 32'd0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic              busy;
    logic              err;

    imem_boot_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .pc(pc),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ready_cycles = 0;
    logic [37:0] wq[$];
    int          wcyc[$];
    logic [7:0]  pgm[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Log every memory write with its cycle stamp
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wq.push_back({mem_addr, mem_wdata});
            wcyc.push_back(cyc);
        end
        if (in_ready === 1'b1) ready_cycles++;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 64'd0, 64'd1);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_cpu_run"}, cpu_run, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic run_load(input int len_req, input int gap_min, input int gap_max, input bit bad_csum);
        int eff, nb, base, rbase, t, exp_n, bad;
        logic [7:0]  cs;
        logic [31:0] w;
        bit exp_err;
        eff = (len_req > DEPTH) ? DEPTH : len_req;
        nb  = eff * 4;
        while (pgm.size() < nb) pgm.push_back(8'($urandom));
        cs = 8'd0;
        for (int i = 0; i < nb; i++) cs ^= pgm[i];
        exp_err = 1'b0;
`ifdef CHECKSUM_EN
        if (eff > 0) begin
            exp_err = bad_csum;
            pgm.push_back(bad_csum ? (cs ^ 8'h01) : cs);
            nb++;
        end
`endif
        @(negedge clk);
        base  = wq.size();
        rbase = ready_cycles;
        start    = 1'b1;
        load_len = (ADDR_W+1)'(len_req);
        @(negedge clk);
        start = 1'b0;
        check("start_cpu_run", cpu_run, 0);
        check("start_busy", busy, 1);
        check("start_in_ready", in_ready, (eff > 0) ? 1 : 0);
        check("start_err", err, 0);
        for (int i = 0; i < nb; i++) send_byte(pgm[i], $urandom_range(gap_max, gap_min));
        t = 0;
        while (!(cpu_run || err) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("done_in_time", (t < 400) ? 1 : 0, 1);
        exp_n = exp_err ? eff : DEPTH;
        check("write_count", wq.size() - base, exp_n);
        for (int k = 0; k < exp_n && base + k < wq.size(); k++) begin
            w = (k < eff) ? {pgm[4*k], pgm[4*k+1], pgm[4*k+2], pgm[4*k+3]} : 32'd0;
            check("write", wq[base + k], {6'(k), w});
        end
        bad = 0;
        for (int k = eff + 1; k < exp_n && base + k < wq.size(); k++)
            if (wcyc[base + k] != wcyc[base + k - 1] + 1) bad++;
        check("clear_consecutive", bad, 0);
        check("end_cpu_run", cpu_run, exp_err ? 0 : 1);
        check("end_busy", busy, 0);
        check("end_err", err, exp_err);
        check("end_in_ready", in_ready, 0);
        if (eff == 0) check("zero_len_no_ready", ready_cycles - rbase, 0);
        pgm.delete();
    endtask

    initial begin
        int ln;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("idle");

        pgm = '{8'h20, 8'h10, 8'h00, 8'h15, 8'h20, 8'h11, 8'h00, 8'h17};
        run_load(2, 0, 0, 1'b0);

        pc = 32'h24;  #1 check("fetch_0x24", mem_addr, 9);
        pc = 32'h100; #1 check("fetch_wrap", mem_addr, 0);
        for (int i = 0; i < 6; i++) begin
            pc = $urandom;
            #1 check("fetch_rand", mem_addr, pc[ADDR_W+1:2]);
        end

        run_load(0, 0, 0, 1'b0);

        pgm = '{8'h20, 8'h10, 8'h00, 8'h15, 8'h20, 8'h11, 8'h00, 8'h17};
        run_load(2, 3, 3, 1'b0);

        run_load(100, 0, 1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            ln = $urandom_range(70, 0);
            run_load(ln, 0, 2, 1'b0);
        end

        @(negedge clk);
        start    = 1'b1;
        load_len = (ADDR_W+1)'(3);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
        #2 rst = 1'b0;
        #1 check_outputs_zero("mid_load_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("after_reset");
        run_load(3, 0, 1, 1'b0);

`ifdef CHECKSUM_EN
        pgm = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 0, 0, 1'b0);
        pgm = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 0, 0, 1'b1);
        repeat (3) @(negedge clk);
        check("err_hold", err, 1);
        check("err_cpu_run", cpu_run, 0);
        run_load(2, 0, 1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
